// File: rtl/disp_pkg.sv
// Shared display codes and FSM encoding for the register display reader.
// The blank/dash codes are also what software loads into registers 30/31.
package disp_pkg;
  localparam int DIGIT_W    = 7;
  localparam int BCD_DIGITS = 10;

  localparam logic [DIGIT_W-1:0] DISP_BLANK = 7'd126;
  localparam logic [DIGIT_W-1:0] DISP_DASH  = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CONVERT,
    ST_FORMAT
  } disp_state_e;
endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter: 32-bit magnitude in,
// 10 BCD nibbles out after exactly 32 clocks following start.
module bin2bcd_serial
  import disp_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [31:0]             mag,
  output logic                    busy,
  output logic                    last,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  logic [31:0]             shreg;
  logic [4:0]              bit_cnt;
  logic [4*BCD_DIGITS-1:0] bcd_next;

  always_comb begin
    bcd_next = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_next[4*BCD_DIGITS-2:0], shreg[31]};
  end

  assign last = busy && (bit_cnt == 5'd31);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      shreg   <= mag;
      bit_cnt <= '0;
      bcd     <= '0;
    end else if (busy) begin
      bcd     <= bcd_next;
      shreg   <= {shreg[30:0], 1'b0};
      bit_cnt <= bit_cnt + 5'd1;
      if (last) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/reg_display_reader.sv
// Reads one bank register and formats it as eight 7-segment digit codes,
// with optional periodic auto-refresh.
//
// state   | meaning
// IDLE    | waiting for start or refresh timeout
// READ    | rd_data valid for rd_addr; sign captured, converter loaded
// CONVERT | 32 shift-add-3 steps in bin2bcd_serial
// FORMAT  | sign/blank/overflow formatting, digits load on exit
module reg_display_reader
  import disp_pkg::*;
#(
  parameter bit SIGNED         = 1'b1,
  parameter int REFRESH_CYCLES = 1000,
  parameter int NUM_DIGITS     = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [4:0]                    reg_sel,
  input  logic                          auto_refresh,
  output logic [4:0]                    rd_addr,
  input  logic [31:0]                   rd_data,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);
  localparam int RW = (REFRESH_CYCLES < 2) ? 1 : $clog2(REFRESH_CYCLES + 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYCLES);

  disp_state_e state, state_next;
  logic [RW-1:0] refresh_cnt;
  logic          accept, neg, neg_r, conv_start, conv_busy, conv_last, fmt_ovf;
  logic [31:0]   mag;
  logic [4*BCD_DIGITS-1:0]       bcd;
  logic [NUM_DIGITS*DIGIT_W-1:0] fmt_digits;
  int            nsig;

  assign accept = (state == ST_IDLE) &&
                  (start || (auto_refresh && (refresh_cnt == REFRESH_MAX)));
  assign neg    = SIGNED && rd_data[31];
  assign mag    = neg ? (~rd_data + 32'd1) : rd_data;

  bin2bcd_serial u_bin2bcd (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (conv_start),
    .mag     (mag),
    .busy    (conv_busy),
    .last    (conv_last),
    .bcd     (bcd)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (accept) state_next = ST_READ;
      ST_READ:    state_next = ST_CONVERT;
      ST_CONVERT: if (conv_last || !conv_busy) state_next = ST_FORMAT;
      ST_FORMAT:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    conv_start = (state == ST_READ);
  end

  // Significant digit count; a zero value still shows one digit.
  always_comb begin
    nsig = 1;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) nsig = i + 1;
    end
    fmt_ovf    = neg_r ? (bcd[39:28] != 12'd0) : (bcd[39:32] != 8'd0);
    fmt_digits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (fmt_ovf)              fmt_digits[i*DIGIT_W +: DIGIT_W] = DISP_DASH;
      else if (i < nsig)        fmt_digits[i*DIGIT_W +: DIGIT_W] = {3'b000, bcd[4*i +: 4]};
      else if (neg_r && i == nsig) fmt_digits[i*DIGIT_W +: DIGIT_W] = DISP_DASH;
      else                      fmt_digits[i*DIGIT_W +: DIGIT_W] = DISP_BLANK;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= '0;
      neg_r    <= 1'b0;
      digits   <= {NUM_DIGITS{DISP_BLANK}};
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_FORMAT);
      if (accept && start)      rd_addr <= reg_sel;
      if (state == ST_READ)     neg_r   <= neg;
      if (state == ST_FORMAT) begin
        digits   <= fmt_digits;
        overflow <= fmt_ovf;
      end
    end
  end

  // Acceptance clears the counter so it stays at zero while busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      refresh_cnt <= '0;
    else if (!auto_refresh || done || accept)
      refresh_cnt <= '0;
    else if ((state == ST_IDLE) && (refresh_cnt != REFRESH_MAX))
      refresh_cnt <= refresh_cnt + 1'b1;
  end
endmodule
